// File: rtl/cart_pkg.sv
// Shared definitions for the cart billing engine: FSM encoding, default
// price table and a helper that extracts one entry from a packed price table.
package cart_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SHOP   = 2'd1;
    localparam state_t ST_BILLED = 2'd2;

    localparam int DEF_N_ITEMS = 4;
    localparam int DEF_PRICE_W = 8;
    localparam logic [DEF_N_ITEMS*DEF_PRICE_W-1:0] DEF_PRICES =
        {8'd40, 8'd30, 8'd20, 8'd10};

    // Widest table the helper can index; callers zero-extend into it.
    localparam int MAX_ITEMS   = 8;
    localparam int MAX_PRICE_W = 16;

    function automatic logic [MAX_PRICE_W-1:0] price_of(
        input logic [MAX_ITEMS*MAX_PRICE_W-1:0] tbl,
        input int unsigned                      price_w,
        input int unsigned                      idx
    );
        logic [MAX_ITEMS*MAX_PRICE_W-1:0] shifted;
        logic [MAX_PRICE_W-1:0]           mask;
        shifted = tbl >> (idx * price_w);
        mask    = ~({MAX_PRICE_W{1'b1}} << price_w);
        return shifted[MAX_PRICE_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/cart_billing_engine_key_debounce.sv
// Push-button conditioner: two-flop synchroniser, tick-sampled run-length
// debouncer, and a one-cycle pulse on each accepted rising level.
module key_debounce #(
    parameter int DEB_N = 3
) (
    input  logic Clk,
    input  logic Rst,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_N + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          last_q, last_d;
    logic [CW-1:0] run_q, run_d;
    logic          level_q, level_d;
    logic          press_q, press_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        last_d  = last_q;
        run_d   = run_q;
        level_d = level_q;
        press_d = 1'b0;
        if (tick) begin
            last_d = sync2_q;
            // Run length of identical samples, saturating at DEB_N.
            if (sync2_q != last_q) begin
                run_d = CW'(1);
            end else if (run_q != CW'(DEB_N)) begin
                run_d = run_q + CW'(1);
            end
            if (run_d >= CW'(DEB_N) && sync2_q != level_q) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            last_q  <= 1'b0;
            run_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            last_q  <= last_d;
            run_q   <= run_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/cart_billing_engine.sv
// Cart biller: debounced product/pay keys, per-cycle press arbitration,
// saturating bill with per-item counts, and a Pay/Ack checkout FSM.
module cart_billing_engine
    import cart_pkg::*;
#(
    parameter int                         N_ITEMS  = DEF_N_ITEMS,
    parameter int                         PRICE_W  = DEF_PRICE_W,
    parameter logic [N_ITEMS*PRICE_W-1:0] PRICES   = DEF_PRICES,
    parameter int                         BILL_W   = 12,
    parameter int                         CNT_W    = 4,
    parameter int                         TICK_DIV = 262144,
    parameter int                         DEB_N    = 3
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [N_ITEMS-1:0]         Key,
    input  logic                       Pay,
    input  logic                       Remove,
    input  logic                       Ack,
    output logic [BILL_W-1:0]          Bill,
    output logic [N_ITEMS*CNT_W-1:0]   Item_count,
    output logic                       Bill_valid,
    output logic                       Overflow,
    output logic                       Err
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
    localparam int SW = ((BILL_W > PRICE_W) ? BILL_W : PRICE_W) + 1;
    localparam logic [MAX_ITEMS*MAX_PRICE_W-1:0] PRICE_TBL =
        (MAX_ITEMS*MAX_PRICE_W)'(PRICES);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [SW-1:0]    BILL_MAX = SW'({BILL_W{1'b1}});

    logic [TW-1:0] div_q, div_d;
    logic          tick_q, tick_d;

    logic [PRICE_W-1:0] price [N_ITEMS];
    logic [N_ITEMS-1:0] key_press;
    logic [N_ITEMS-1:0] key_level;
    logic               pay_press;
    logic               pay_level;

    state_t                          state_q, state_d;
    logic [BILL_W-1:0]               bill_q, bill_d;
    logic [N_ITEMS-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic                            ovf_q, ovf_d;
    logic                            err_q, err_d;

    logic [IW-1:0]      sel_idx;
    logic [PRICE_W-1:0] sel_price;
    logic [SW-1:0]      add_sum;
    logic [SW-1:0]      sub_val;
    logic               add_ok;
    logic               single_press;
    logic               multi_press;
    logic               prod_ok;

    // Accepted levels are not needed downstream; only the edges matter.
    logic unused_levels;
    assign unused_levels = &{1'b0, key_level, pay_level};

    always_comb begin
        tick_d = (div_q == TW'(TICK_DIV - 1));
        div_d  = tick_d ? '0 : div_q + TW'(1);
    end

    generate
        for (genvar gi = 0; gi < N_ITEMS; gi++) begin : g_key
            key_debounce #(.DEB_N(DEB_N)) u_deb (
                .Clk   (Clk),
                .Rst   (Rst),
                .tick  (tick_q),
                .raw   (Key[gi]),
                .level (key_level[gi]),
                .press (key_press[gi])
            );
            assign price[gi] = PRICE_W'(price_of(PRICE_TBL, PRICE_W, gi));
        end
    endgenerate

    key_debounce #(.DEB_N(DEB_N)) u_pay_deb (
        .Clk   (Clk),
        .Rst   (Rst),
        .tick  (tick_q),
        .raw   (Pay),
        .level (pay_level),
        .press (pay_press)
    );

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (key_press[i]) begin
                sel_idx = IW'(i);
            end
        end
    end

    assign single_press = $onehot(key_press);
    assign multi_press  = (|key_press) && !single_press;
    assign prod_ok      = single_press && !pay_press;
    assign sel_price    = price[sel_idx];
    assign add_sum      = SW'(bill_q) + SW'(sel_price);
    assign sub_val      = (SW'(bill_q) >= SW'(sel_price)) ?
                          (SW'(bill_q) - SW'(sel_price)) : '0;
    assign add_ok       = (cnt_q[sel_idx] != CNT_MAX) && (add_sum <= BILL_MAX);

    always_comb begin
        state_d = state_q;
        bill_d  = bill_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        // Colliding presses are dropped; Pay beats a simultaneous product.
        err_d   = multi_press || (pay_press && single_press);
        case (state_q)
            ST_IDLE, ST_SHOP: begin
                if (pay_press) begin
                    if (state_q == ST_SHOP) begin
                        state_d = ST_BILLED;
                    end
                end else if (prod_ok) begin
                    if (Remove) begin
                        if (cnt_q[sel_idx] == '0) begin
                            err_d = 1'b1;
                        end else begin
                            cnt_d[sel_idx] = cnt_q[sel_idx] - CNT_W'(1);
                            bill_d         = BILL_W'(sub_val);
                        end
                    end else if (add_ok) begin
                        cnt_d[sel_idx] = cnt_q[sel_idx] + CNT_W'(1);
                        bill_d         = BILL_W'(add_sum);
                        state_d        = ST_SHOP;
                    end else begin
                        ovf_d = 1'b1;
                        err_d = 1'b1;
                    end
                end
                if (state_q == ST_SHOP && !pay_press && cnt_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BILLED: begin
                if (prod_ok) begin
                    err_d = 1'b1;
                end
                if (Ack) begin
                    state_d = ST_IDLE;
                    bill_d  = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            div_q   <= '0;
            tick_q  <= 1'b0;
            state_q <= ST_IDLE;
            bill_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            tick_q  <= tick_d;
            state_q <= state_d;
            bill_q  <= bill_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign Bill       = bill_q;
    assign Item_count = cnt_q;
    assign Bill_valid = (state_q == ST_BILLED);
    assign Overflow   = ovf_q;
    assign Err        = err_q;

endmodule

// File: tb/tb_cart_billing_engine.sv
// Scenario bench for cart_billing_engine: a reference cart model feeds a
// scoreboard queue that is popped and compared after each transaction.
module tb_cart_billing_engine;

    typedef struct packed {
        logic [11:0] bill;
        logic [15:0] cnts;
        logic        valid;
        logic        ovf;
        logic [7:0]  errs;
    } snap_t;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [3:0]  Key = 4'b0;
    logic        Pay = 1'b0;
    logic        Remove = 1'b0;
    logic        Ack = 1'b0;

    logic [11:0] bill;
    logic [15:0] item_count;
    logic        bill_valid, overflow, err;
    logic [5:0]  s_bill;
    logic [15:0] s_count;
    logic        s_valid, s_ovf, s_err;

    int n_tests  = 0;
    int n_failed = 0;

    int m_bill;
    int m_cnt[4];
    int m_state;
    bit m_ovf;
    int price_tab[4] = '{10, 20, 30, 40};

    int    big_errs;
    int    small_errs;
    snap_t sb[$];

    always #5 Clk = ~Clk;

    cart_billing_engine #(.TICK_DIV(4), .DEB_N(2)) dut (
        .Clk(Clk), .Rst(Rst), .Key(Key), .Pay(Pay), .Remove(Remove), .Ack(Ack),
        .Bill(bill), .Item_count(item_count), .Bill_valid(bill_valid),
        .Overflow(overflow), .Err(err)
    );

    cart_billing_engine #(.BILL_W(6), .TICK_DIV(4), .DEB_N(2)) dut_small (
        .Clk(Clk), .Rst(Rst), .Key(Key), .Pay(Pay), .Remove(Remove), .Ack(Ack),
        .Bill(s_bill), .Item_count(s_count), .Bill_valid(s_valid),
        .Overflow(s_ovf), .Err(s_err)
    );

    function automatic string fmt(input snap_t s);
        return $sformatf("bill=%0d cnt=%h valid=%0d ovf=%0d errs=%0d",
                         s.bill, s.cnts, s.valid, s.ovf, s.errs);
    endfunction

    function automatic void model_reset();
        m_bill  = 0;
        m_state = 0;
        m_ovf   = 1'b0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endfunction

    function automatic snap_t model_snap(input int errs);
        snap_t s;
        s.bill  = 12'(m_bill);
        s.cnts  = '0;
        for (int i = 0; i < 4; i++) s.cnts[i*4 +: 4] = 4'(m_cnt[i]);
        s.valid = (m_state == 2);
        s.ovf   = m_ovf;
        s.errs  = 8'(errs);
        return s;
    endfunction

    function automatic int model_press(input logic [3:0] keys, input logic pay, input logic rem);
        int n = $countones(keys);
        int e = 0;
        int i = 0;
        for (int k = 0; k < 4; k++) if (keys[k]) i = k;
        if (n > 1) e = 1;
        if (pay) begin
            if (n == 1) e = 1;
            if (m_state == 1) m_state = 2;
        end else if (n == 1) begin
            if (m_state == 2) begin
                e = 1;
            end else if (rem) begin
                if (m_cnt[i] == 0) e = 1;
                else begin
                    m_cnt[i] -= 1;
                    m_bill   -= price_tab[i];
                end
                if (m_state == 1 && m_cnt.sum() == 0) m_state = 0;
            end else if (m_cnt[i] == 15 || m_bill + price_tab[i] > 4095) begin
                e     = 1;
                m_ovf = 1'b1;
            end else begin
                m_cnt[i] += 1;
                m_bill   += price_tab[i];
                m_state   = 1;
            end
        end
        return e;
    endfunction

    function automatic snap_t observe();
        snap_t s;
        s.bill  = bill;
        s.cnts  = item_count;
        s.valid = bill_valid;
        s.ovf   = overflow;
        s.errs  = 8'(big_errs);
        return s;
    endfunction

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(negedge Clk);
            big_errs   += int'(err);
            small_errs += int'(s_err);
        end
    endtask

    task automatic press(input logic [3:0] keys, input logic pay, input logic rem,
                         output snap_t obs);
        int e;
        e = model_press(keys, pay, rem);
        sb.push_back(model_snap(e));
        @(negedge Clk);
        Remove     = rem;
        Key        = keys;
        Pay        = pay;
        big_errs   = 0;
        small_errs = 0;
        run_cycles(40);
        Key = 4'b0;
        Pay = 1'b0;
        run_cycles(40);
        Remove = 1'b0;
        obs = observe();
    endtask

    task automatic do_ack(output snap_t obs);
        if (m_state == 2) begin
            model_reset();
        end
        sb.push_back(model_snap(0));
        @(negedge Clk);
        big_errs   = 0;
        small_errs = 0;
        Ack = 1'b1;
        run_cycles(1);
        Ack = 1'b0;
        run_cycles(3);
        obs = observe();
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b0;
        run_cycles(3);
        Rst = 1'b1;
        model_reset();
        run_cycles(2);
    endtask

    task automatic test_reset();
        snap_t obs, exp;
        @(negedge Clk);
        Rst = 1'b0;
        repeat (4) @(negedge Clk);
        Rst = 1'b1;
        model_reset();
        sb.push_back(model_snap(0));
        big_errs = 0;
        run_cycles(4);
        obs = observe();
        exp = sb.pop_front();
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL reset_state: got %s, expected %s", fmt(obs), fmt(exp));
        end
        n_tests++;
        if (s_bill !== 6'd0 || s_ovf !== 1'b0 || s_valid !== 1'b0) begin
            n_failed++;
            $display("FAIL reset_small: got bill=%0d ovf=%0d valid=%0d, expected 0 0 0",
                     s_bill, s_ovf, s_valid);
        end
        $display("[TB] reset: %s", fmt(obs));
    endtask

    task automatic test_checkout();
        snap_t obs, exp;
        logic [3:0] seq [4] = '{4'b0001, 4'b0001, 4'b1000, 4'b0000};
        for (int i = 0; i < 4; i++) begin
            press(seq[i], (i == 3), 1'b0, obs);
            exp = sb.pop_front();
            n_tests++;
            if (obs !== exp) begin
                n_failed++;
                $display("FAIL checkout_step%0d: got %s, expected %s", i, fmt(obs), fmt(exp));
            end
            $display("[TB] checkout step %0d: %s", i, fmt(obs));
        end
        n_tests++;
        if (bill !== 12'd60 || bill_valid !== 1'b1) begin
            n_failed++;
            $display("FAIL checkout_total: got bill=%0d valid=%0d, expected 60 1", bill, bill_valid);
        end
        do_ack(obs);
        exp = sb.pop_front();
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL checkout_ack: got %s, expected %s", fmt(obs), fmt(exp));
        end
        $display("[TB] checkout ack: %s", fmt(obs));
    endtask

    task automatic test_remove();
        snap_t obs, exp;
        logic [3:0] keys [4] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000};
        logic       rems [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        // Last step: Pay in IDLE must be ignored without Err.
        for (int i = 0; i < 4; i++) begin
            press(keys[i], (i == 3), rems[i], obs);
            exp = sb.pop_front();
            n_tests++;
            if (obs !== exp) begin
                n_failed++;
                $display("FAIL remove_step%0d: got %s, expected %s", i, fmt(obs), fmt(exp));
            end
            $display("[TB] remove step %0d: %s", i, fmt(obs));
        end
    endtask

    task automatic test_bounce();
        snap_t obs, exp;
        int e;
        e = model_press(4'b0010, 1'b0, 1'b0);
        sb.push_back(model_snap(e));
        @(negedge Clk);
        big_errs = 0;
        for (int t = 0; t < 5; t++) begin
            Key[1] = ~t[0];
            run_cycles(4);
        end
        Key[1] = 1'b1;
        run_cycles(40);
        Key[1] = 1'b0;
        run_cycles(40);
        obs = observe();
        exp = sb.pop_front();
        n_tests++;
        if (obs !== exp || obs.bill !== 12'd20) begin
            n_failed++;
            $display("FAIL bounce_single_add: got %s, expected %s", fmt(obs), fmt(exp));
        end
        $display("[TB] bounce: %s", fmt(obs));
        do_ack(obs);
        exp = sb.pop_front();
        do_reset();
    endtask

    task automatic test_collision();
        snap_t obs, exp;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            press(4'b0001, 1'b0, 1'b0, obs);
            exp = sb.pop_front();
        end
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL collision_fill: got %s, expected %s", fmt(obs), fmt(exp));
        end
        press(4'b0011, 1'b0, 1'b0, obs);
        exp = sb.pop_front();
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL collision_two_keys: got %s, expected %s", fmt(obs), fmt(exp));
        end
        $display("[TB] collision two keys: %s", fmt(obs));
        press(4'b0001, 1'b0, 1'b0, obs);
        exp = sb.pop_front();
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL collision_big_add: got %s, expected %s", fmt(obs), fmt(exp));
        end
        n_tests++;
        if (s_bill !== 6'd60 || s_ovf !== 1'b1 || small_errs != 1) begin
            n_failed++;
            $display("FAIL small_bill_saturate: got bill=%0d ovf=%0d errs=%0d, expected 60 1 1",
                     s_bill, s_ovf, small_errs);
        end
        $display("[TB] small saturate: bill=%0d ovf=%0d", s_bill, s_ovf);
        press(4'b0010, 1'b1, 1'b0, obs);
        exp = sb.pop_front();
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL collision_pay_key: got %s, expected %s", fmt(obs), fmt(exp));
        end
        $display("[TB] collision pay+key: %s", fmt(obs));
        do_ack(obs);
        exp = sb.pop_front();
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL collision_ack: got %s, expected %s", fmt(obs), fmt(exp));
        end
    endtask

    task automatic test_count_sat();
        snap_t obs, exp;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            press(4'b0001, 1'b0, 1'b0, obs);
            exp = sb.pop_front();
        end
        n_tests++;
        if (obs !== exp || obs.cnts[3:0] !== 4'd15) begin
            n_failed++;
            $display("FAIL count_fill: got %s, expected %s", fmt(obs), fmt(exp));
        end
        press(4'b0001, 1'b0, 1'b0, obs);
        exp = sb.pop_front();
        n_tests++;
        if (obs !== exp || obs.ovf !== 1'b1) begin
            n_failed++;
            $display("FAIL count_saturate: got %s, expected %s", fmt(obs), fmt(exp));
        end
        $display("[TB] count saturate: %s", fmt(obs));
        press(4'b0000, 1'b1, 1'b0, obs);
        exp = sb.pop_front();
        press(4'b0010, 1'b0, 1'b0, obs);
        exp = sb.pop_front();
        n_tests++;
        if (obs !== exp || obs.bill !== 12'd150) begin
            n_failed++;
            $display("FAIL billed_key_held: got %s, expected %s", fmt(obs), fmt(exp));
        end
        $display("[TB] billed key: %s", fmt(obs));
        do_ack(obs);
        exp = sb.pop_front();
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL count_ack_clear: got %s, expected %s", fmt(obs), fmt(exp));
        end
    endtask

    task automatic test_reset_mid();
        snap_t obs, exp;
        logic [3:0] seq [4] = '{4'b1000, 4'b1000, 4'b0001, 4'b0000};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            press(seq[i], (i == 3), 1'b0, obs);
            exp = sb.pop_front();
        end
        n_tests++;
        if (obs !== exp || obs.bill !== 12'd90 || obs.valid !== 1'b1) begin
            n_failed++;
            $display("FAIL mid_billed: got %s, expected %s", fmt(obs), fmt(exp));
        end
        n_tests++;
        if (s_ovf !== 1'b1) begin
            n_failed++;
            $display("FAIL mid_small_ovf: got %0d, expected 1", s_ovf);
        end
        @(negedge Clk);
        Rst = 1'b0;
        model_reset();
        sb.push_back(model_snap(0));
        big_errs = 0;
        @(negedge Clk);
        obs = observe();
        exp = sb.pop_front();
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL mid_reset: got %s, expected %s", fmt(obs), fmt(exp));
        end
        n_tests++;
        if (s_ovf !== 1'b0 || s_bill !== 6'd0) begin
            n_failed++;
            $display("FAIL mid_reset_small: got ovf=%0d bill=%0d, expected 0 0", s_ovf, s_bill);
        end
        $display("[TB] reset mid-checkout: %s", fmt(obs));
        Rst = 1'b1;
        run_cycles(2);
    endtask

    initial begin
        big_errs   = 0;
        small_errs = 0;
        model_reset();
        test_reset();
        test_checkout();
        test_remove();
        test_bounce();
        test_collision();
        test_count_sat();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
